// File: rtl/cla_wide_add_seq_pkg.sv
// Shared definitions for the wide-add sequencer: FSM state encoding and
// the width of one datapath word.
package cla_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int WORD_W = 64;

endpackage

// File: rtl/cla_wide_add_seq_if.sv
// Host-side bus of the wide-add sequencer: start request, operands, carry-in,
// and the busy/done/result outputs. With CLA_WIDE_SUB_EN defined the bus also
// carries the subtract select.
interface cla_wide_add_seq_if
  import cla_seq_pkg::*;
#(
  parameter int WORDS = 4
);
  localparam int W = WORDS * WORD_W;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef CLA_WIDE_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

`ifdef CLA_WIDE_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/cla_wide_add_seq_cla64.sv
// 64-bit carry-lookahead adder: 4-bit lookahead groups, with group carries
// chained across the sixteen groups. gp/gg are the whole-word propagate and
// generate terms for use by a higher lookahead level.
module CLA_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout,
  output logic        gp,
  output logic        gg
);
  logic [63:0] g;
  logic [63:0] p;
  logic [64:0] c;
  logic [15:0] grp_g;
  logic [15:0] grp_p;

  // Bit and group generate/propagate, in-group lookahead carries, sum bits.
  always_comb begin
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    grp_g = '0;
    grp_p = '0;
    gg    = 1'b0;
    c[0]  = cin;
    for (int k = 0; k < 16; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = grp_g[k] | (grp_p[k] & c[4*k]);
      gg       = grp_g[k] | (grp_p[k] & gg);
    end
    sum  = p ^ c[63:0];
    cout = c[64];
    gp   = &grp_p;
  end

endmodule

// File: rtl/cla_wide_add_seq.sv
// Multi-precision adder sequencer: adds two WORDS x 64-bit operands through one
// shared CLA_64bit, least-significant word first, chaining the carry through a
// register. Optional subtract mode is enabled by defining CLA_WIDE_SUB_EN.
module cla_wide_add_seq
  import cla_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  cla_wide_add_seq_if.slave bus
);
  localparam int W  = WORDS * WORD_W;
  localparam int CW = $clog2(WORDS);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     idx_q;
  logic [W-1:0]      opa_q, opb_q, sum_q;
  logic              carry_q, cout_q;
  logic [W-1:0]      b_in;
  logic              c_in;
  logic              last;
  logic [WORD_W-1:0] word_a, word_b, word_s;
  logic              word_c;
  logic              unused_gp, unused_gg;

  // Subtraction is a + ~b + 1, so only the captured B and carry differ.
`ifdef CLA_WIDE_SUB_EN
  assign b_in = bus.sub ? ~bus.b : bus.b;
  assign c_in = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_in = bus.b;
  assign c_in = bus.cin;
`endif

  assign last   = (idx_q == CW'(WORDS - 1));
  assign word_a = opa_q[idx_q*WORD_W +: WORD_W];
  assign word_b = opb_q[idx_q*WORD_W +: WORD_W];

  // Whole-word group terms are not needed; the carry goes through carry_q.
  CLA_64bit u_cla (
    .a    (word_a),
    .b    (word_b),
    .cin  (carry_q),
    .sum  (word_s),
    .cout (word_c),
    .gp   (unused_gp),
    .gg   (unused_gg)
  );

  // Next state: start taken only in IDLE, DONE always lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (last)      state_d = ST_DONE;
      ST_DONE:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Operand capture, per-word result write-back, carry chaining, final carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            opa_q   <= bus.a;
            opb_q   <= b_in;
            carry_q <= c_in;
            idx_q   <= '0;
          end
        end
        ST_RUN: begin
          sum_q[idx_q*WORD_W +: WORD_W] <= word_s;
          carry_q <= word_c;
          if (last) cout_q <= word_c;
          else      idx_q  <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_cla_wide_add_seq.sv
// Scoreboard bench for cla_wide_add_seq (WORDS=4). Define CLA_WIDE_SUB_EN to
// add the subtract-mode vectors.
module tb_cla_wide_add_seq;
  import cla_seq_pkg::*;

  localparam int WORDS = 4;
  localparam int W     = WORDS * WORD_W;

  typedef struct {
    logic [W:0] val;
    longint     cyc;
    string      name;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     checks = 0;
  int     errors = 0;
  int     done_cnt = 0;
  longint cyc = 0;
  logic   prev_done = 1'b0;
  exp_t   sb[$];

  cla_wide_add_seq_if #(.WORDS(WORDS)) bif ();

  cla_wide_add_seq #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected result and checks value,
  // arrival cycle and single-cycle width.
  always @(negedge clk) begin
    exp_t e;
    if (bif.done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done high at cycle %0d with nothing pending", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, {bif.cout, bif.sum}, e.val);
        check_int({e.name, "_latency"}, cyc, e.cyc);
        check_int({e.name, "_width"}, longint'(prev_done), 0);
      end
    end
    prev_done = bif.done;
  end

  // Wait for IDLE, present operands with start for one cycle; the result is
  // expected during the cycle after edge E0+WORDS.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input bit push, input string name, input logic [W:0] exp);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (bif.busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_wait: busy=%b after 50 cycles, required 0", name, bif.busy);
    end
    bif.a     = a;
    bif.b     = b;
    bif.cin   = cin;
    bif.start = 1'b1;
    if (push) begin
      e.val  = exp;
      e.cyc  = cyc + 1 + WORDS;
      e.name = name;
      sb.push_back(e);
    end
    @(negedge clk);
    bif.start = 1'b0;
  endtask

`ifdef CLA_WIDE_SUB_EN
  task automatic issue_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                           input string name, input logic [W:0] exp);
    bif.sub = 1'b1;
    issue(a, b, 1'b0, 1'b1, name, exp);
    bif.sub = 1'b0;
  endtask
`endif

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || bif.busy !== 1'b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: pending=%0d busy=%b after 100 cycles, required 0/0",
               name, sb.size(), bif.busy);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   rexp;

    bif.start = 1'b0;
    bif.a     = '0;
    bif.b     = '0;
    bif.cin   = 1'b0;
`ifdef CLA_WIDE_SUB_EN
    bif.sub   = 1'b0;
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    check_int("reset_busy", longint'(bif.busy), 0);
    check_int("reset_done", longint'(bif.done), 0);
    check("reset_result", {bif.cout, bif.sum}, '0);
    rst = 1'b0;

    // Carry ripples through all four words.
    issue({W{1'b1}}, '0, 1'b1, 1'b1, "ripple", {1'b1, {W{1'b0}}});
    wait_idle("ripple");

    // Carry crossing one word boundary, then result hold in IDLE.
    issue({192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, W'(1), 1'b0, 1'b1, "boundary",
          {1'b0, 128'd0, 64'h0000_0000_0000_0001, 64'h0});
    wait_idle("boundary");
    repeat (4) @(negedge clk);
    check("boundary_hold", {bif.cout, bif.sum}, {1'b0, 128'd0, 64'h0000_0000_0000_0001, 64'h0});

    // Start while busy is dropped, not queued.
    d0 = done_cnt;
    issue(W'(5), W'(7), 1'b0, 1'b1, "busy_first", (W+1)'(12));
    @(negedge clk);
    bif.a     = W'(100);
    bif.b     = '0;
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    wait_idle("busy_first");
    repeat (6) @(negedge clk);
    check_int("busy_one_done", done_cnt - d0, 1);
    issue(W'(100), '0, 1'b0, 1'b1, "busy_fresh", (W+1)'(100));
    wait_idle("busy_fresh");

    // Asynchronous reset in the second RUN cycle discards the operation.
    d0 = done_cnt;
    issue(W'(3), W'(4), 1'b0, 1'b0, "mid_reset", '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_int("mid_reset_busy", longint'(bif.busy), 0);
    check("mid_reset_result", {bif.cout, bif.sum}, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check_int("mid_reset_no_done", done_cnt - d0, 0);
    issue(W'(3), W'(4), 1'b1, 1'b1, "after_reset", (W+1)'(8));
    wait_idle("after_reset");

    // Random regression against a full-width reference sum.
    for (int i = 0; i < 200; i++) begin
      ra   = rand_word();
      rb   = rand_word();
      rc   = 1'($urandom_range(0, 1));
      rexp = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
      issue(ra, rb, rc, 1'b1, "random", rexp);
    end
    wait_idle("random");

`ifdef CLA_WIDE_SUB_EN
    issue_sub(W'(10), W'(3), "sub_pos", (W+1)'({1'b1, 256'd7}));
    issue_sub(W'(3), W'(10), "sub_neg",
              {1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9});
    wait_idle("sub");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cla_wide_add_seq.md
Name: cla_wide_add_seq

Overview:
- Multi-precision adder sequencer. Adds two WORDS×64-bit operands using a single shared CLA_64bit instance, one 64-bit word per cycle, least-significant word first.
- The carry is chained through a register between words.
- Sits between a host/control block and the existing 64-bit CLA datapath. Gives wide arithmetic without replicating adder hardware.

Parameters:
- WORDS, 4, number of 64-bit words per operand (≥2); operand width W = WORDS*64.
- CW, $clog2(WORDS), word-index counter width (derived localparam).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new addition; sampled only in IDLE.
- a  in  W  operand A; captured on the accepted start.
- b  in  W  operand B; captured on the accepted start.
- cin  in  1  carry-in to word 0; captured on the accepted start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse: result valid.
- sum  out  W  result register.
- cout  out  1  final carry-out of the most-significant word.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, sum=0, cout=0; idx=0, carry register=0, operand registers=0.
- FSM states:
  - IDLE: on start=1, latch a→opa, b→opb, cin→carry, idx←0; go to RUN.
  - RUN: each cycle CLA_64bit gets opa[idx*64+:64], opb[idx*64+:64], carry. On the clock edge: sum[idx*64+:64]←CLA sum, carry←CLA cout, idx←idx+1. When idx==WORDS-1: cout←CLA cout and go to DONE.
  - DONE: done=1 for exactly one cycle; unconditionally return to IDLE.
- Latency:
  - start accepted at edge E0; RUN occupies edges E1..E(WORDS); done is high during the cycle after E(WORDS).
  - Start-to-done is WORDS+1 cycles. Back-to-back throughput: one operation per WORDS+2 cycles.
- Handshake:
  - start is a level sampled only in IDLE; start while busy=1 is ignored, not queued.
  - start held high continuously re-triggers on each IDLE cycle.
  - a, b and cin may change freely after acceptance; captured copies are used.
- Output hold:
  - sum and cout hold their values from done until the next accepted start.
  - During RUN, sum is partially updated and not valid. cout is written only at the last word.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(W+1). The intermediate carry is never exposed.
- The gp/gg outputs of CLA_64bit are left unconnected.
- Reset mid-operation: immediate return to the reset values listed above. No done pulse; the partial result is discarded.
- idx never wraps past WORDS-1; the terminal compare uses ==WORDS-1.

Optional Feature:
- Macro: CLA_WIDE_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), captured with start.
  - When sub=1: opb←~b and carry←1 (cin ignored), giving a − b.
  - cout=1 means no borrow (a ≥ b unsigned).
- Undefined: port absent; addition only; identical timing either way.

Decomposition:
- Shared package cla_seq_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - WORD_W=64.
- Sub-module: instantiate the existing CLA_64bit as the sole datapath. No new sub-module; control, the operand/result registers and the carry register live in cla_wide_add_seq.

Test Plan (WORDS=4):
- Carry ripple across all words:
  - Stimulus: a = all ones (256'hFF…F), b=0, cin=1.
  - Response: sum=0, cout=1; done pulses exactly 5 cycles after the start edge, width 1.
- Word-boundary carry:
  - Stimulus: a=256'h0…0_FFFFFFFFFFFFFFFF, b=1, cin=0.
  - Response: sum=256'h0…1_0000000000000000, cout=0.
- Start while busy ignored:
  - Stimulus: a=5, b=7, cin=0, then start reasserted with a=100 two cycles later.
  - Response: sum=12; exactly one done pulse; a fresh start after return to IDLE yields the new result.
- Reset mid-run:
  - Stimulus: assert rst in the second RUN cycle.
  - Response: sum=0, cout=0, busy=0 immediately (asynchronous); no done pulse. The next operation, 3+4+1, gives 8.
- Random regression:
  - Stimulus: 200 random a, b, cin.
  - Response: {cout,sum} matches the reference a+b+cin in every case.
- With CLA_WIDE_SUB_EN:
  - Stimulus: a=10, b=3, sub=1 → sum=7, cout=1.
  - Stimulus: a=3, b=10, sub=1 → sum=2^256−7, cout=0.
